// File: rtl/fir_filter.sv
// fir_filter: 11-tap FIR engine.
//   Host side   : AXI4-Lite (aw/w/ar/r) for ap_ctrl (0x00), data_length (0x10)
//                 and taps h[k] at 0x20+4k.
//   Stream side : AXI4-Stream ss_* (input samples), sm_* (filter outputs).
//   Memory side : tap_* (coefficient BRAM), data_* (delay-line BRAM), both
//                 external 32-bit, byte-enabled, one-cycle registered read.
//   Clock/reset : axis_clk, axis_rst_n (asynchronous, active-low).
// Optional feature macro FIR_SS_TLAST_EN: when defined, the run completes on
// the output belonging to the sample accepted with ss_tlast=1; otherwise
// ss_tlast is ignored and completion follows the data_length count.
module fir_filter #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11
) (
  output logic                   awready,
  output logic                   wready,
  input  logic                   awvalid,
  input  logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   wvalid,
  input  logic [pDATA_WIDTH-1:0] wdata,
  output logic                   arready,
  input  logic                   rready,
  input  logic                   arvalid,
  input  logic [pADDR_WIDTH-1:0] araddr,
  output logic                   rvalid,
  output logic [pDATA_WIDTH-1:0] rdata,
  input  logic                   ss_tvalid,
  input  logic [pDATA_WIDTH-1:0] ss_tdata,
  input  logic                   ss_tlast,
  output logic                   ss_tready,
  input  logic                   sm_tready,
  output logic                   sm_tvalid,
  output logic [pDATA_WIDTH-1:0] sm_tdata,
  output logic                   sm_tlast,
  output logic [3:0]             tap_WE,
  output logic                   tap_EN,
  output logic [pDATA_WIDTH-1:0] tap_Di,
  output logic [pADDR_WIDTH-1:0] tap_A,
  input  logic [pDATA_WIDTH-1:0] tap_Do,
  output logic [3:0]             data_WE,
  output logic                   data_EN,
  output logic [pDATA_WIDTH-1:0] data_Di,
  output logic [pADDR_WIDTH-1:0] data_A,
  input  logic [pDATA_WIDTH-1:0] data_Do,
  input  logic                   axis_clk,
  input  logic                   axis_rst_n
);

  localparam logic [pADDR_WIDTH-1:0] ADDR_CTRL = '0;
  localparam logic [pADDR_WIDTH-1:0] ADDR_LEN  = pADDR_WIDTH'(16);
  localparam logic [pADDR_WIDTH-1:0] TAP_BASE  = pADDR_WIDTH'(32);
  localparam logic [pADDR_WIDTH-1:0] TAP_LAST  = pADDR_WIDTH'(32 + 4 * (Tape_Num - 1));
  localparam logic [3:0]             LAST_IDX  = 4'(Tape_Num - 1);
  localparam logic [3:0]             NUM_TAPS  = 4'(Tape_Num);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_WAIT_IN, S_MAC, S_OUT, S_DONE} state_e;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_WAIT, R_RESP} rd_state_e;

  function automatic logic is_tap(input logic [pADDR_WIDTH-1:0] a);
    return (a >= TAP_BASE) && (a <= TAP_LAST) && (a[1:0] == 2'b00);
  endfunction

  state_e                   state_q, state_d;
  rd_state_e                rd_q, rd_d;
  logic                     awready_q;
  logic [pADDR_WIDTH-1:0]   araddr_q, araddr_d;
  logic                     tap_rd_ok_q, tap_rd_ok_d;
  logic [pDATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                     ap_done_q, ap_done_d;
  logic [pDATA_WIDTH-1:0]   data_length_q, data_length_d;
  logic [3:0]               cnt_q, cnt_d;
  logic [3:0]               p_q, p_d;
  logic [3:0]               dp_q, dp_d;
  logic [pDATA_WIDTH-1:0]   acc_q, acc_d;
  logic [pDATA_WIDTH-1:0]   y_q, y_d;

  logic                     host_idle;
  logic                     wr_commit;
  logic                     wr_pending;
  logic                     tap_wr;
  logic                     start_pulse;
  logic                     is_last;
  logic                     eng_tap_rd;
  logic [pADDR_WIDTH-1:0]   eng_tap_a;
  logic [pDATA_WIDTH-1:0]   prod;

  assign host_idle   = (state_q == S_IDLE) || (state_q == S_DONE);
  assign wr_commit   = awready_q && awvalid && wvalid;
  assign wr_pending  = awvalid && wvalid && !awready_q;
  assign tap_wr      = wr_commit && host_idle && is_tap(awaddr);
  assign start_pulse = wr_commit && host_idle && (awaddr == ADDR_CTRL) && wdata[0];
  assign prod        = $signed(tap_Do) * $signed(data_Do);

  assign awready   = awready_q;
  assign wready    = awready_q;
  assign arready   = (rd_q == R_ADDR);
  assign rvalid    = (rd_q == R_RESP);
  assign rdata     = rdata_q;
  assign sm_tdata  = y_q;
  assign sm_tlast  = (state_q == S_OUT) && is_last;

`ifdef FIR_SS_TLAST_EN
  logic last_q;
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      last_q <= 1'b0;
    end else if (state_q == S_WAIT_IN && ss_tvalid) begin
      last_q <= ss_tlast;
    end
  end
  assign is_last = last_q;
`else
  logic [pDATA_WIDTH-1:0] out_cnt_q;
  logic                   unused_ss_tlast;
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      out_cnt_q <= '0;
    end else if (start_pulse) begin
      out_cnt_q <= '0;
    end else if (state_q == S_OUT && sm_tready) begin
      out_cnt_q <= out_cnt_q + 1'b1;
    end
  end
  assign is_last         = (out_cnt_q == data_length_q - 1'b1);
  assign unused_ss_tlast = ss_tlast;
`endif

  // AXI-Lite read channel. A read is not accepted in the cycle before a
  // write commits, so the host BRAM read slot never collides with a tap write.
  always_comb begin
    rd_d        = rd_q;
    araddr_d    = araddr_q;
    rdata_d     = rdata_q;
    tap_rd_ok_d = tap_rd_ok_q;
    unique case (rd_q)
      R_IDLE: if (arvalid && !wr_pending) begin
        araddr_d = araddr;
        rd_d     = R_ADDR;
      end
      R_ADDR: begin
        tap_rd_ok_d = host_idle;
        rd_d        = R_WAIT;
      end
      R_WAIT: begin
        if (araddr_q == ADDR_CTRL) begin
          rdata_d = pDATA_WIDTH'({host_idle, ap_done_q, 1'b0});
        end else if (araddr_q == ADDR_LEN) begin
          rdata_d = data_length_q;
        end else if (is_tap(araddr_q) && tap_rd_ok_q) begin
          rdata_d = tap_Do;
        end else begin
          rdata_d = '0;
        end
        rd_d = R_RESP;
      end
      R_RESP: if (rready) rd_d = R_IDLE;
      default: rd_d = R_IDLE;
    endcase
  end

  // Engine: INIT zeroes the delay line; per sample, MAC issues 11 paired
  // reads (cnt 0..10) and accumulates one cycle behind (cnt 1..11).
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    p_d           = p_q;
    dp_d          = dp_q;
    acc_d         = acc_q;
    y_d           = y_q;
    ap_done_d     = ap_done_q;
    data_length_d = data_length_q;
    ss_tready     = 1'b0;
    sm_tvalid     = 1'b0;
    data_EN       = 1'b0;
    data_WE       = '0;
    data_A        = '0;
    data_Di       = '0;
    eng_tap_rd    = 1'b0;
    eng_tap_a     = '0;

    if (wr_commit && awaddr == ADDR_LEN) data_length_d = wdata;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start_pulse) begin
          ap_done_d = 1'b0;
          cnt_d     = '0;
          state_d   = S_INIT;
        end
      end
      S_INIT: begin
        data_EN = 1'b1;
        data_WE = '1;
        data_A  = pADDR_WIDTH'({cnt_q, 2'b00});
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) begin
          p_d     = '0;
          state_d = S_WAIT_IN;
        end
      end
      S_WAIT_IN: begin
        ss_tready = 1'b1;
        if (ss_tvalid) begin
          data_EN = 1'b1;
          data_WE = '1;
          data_A  = pADDR_WIDTH'({p_q, 2'b00});
          data_Di = ss_tdata;
          acc_d   = '0;
          cnt_d   = '0;
          dp_d    = p_q;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        if (cnt_q < NUM_TAPS) begin
          eng_tap_rd = 1'b1;
          eng_tap_a  = pADDR_WIDTH'({cnt_q, 2'b00});
          data_EN    = 1'b1;
          data_A     = pADDR_WIDTH'({dp_q, 2'b00});
          dp_d       = (dp_q == '0) ? LAST_IDX : dp_q - 1'b1;
        end
        if (cnt_q != '0) acc_d = acc_q + prod;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == NUM_TAPS) begin
          y_d     = acc_q + prod;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        sm_tvalid = 1'b1;
        if (sm_tready) begin
          p_d = (p_q == LAST_IDX) ? '0 : p_q + 1'b1;
          if (is_last) begin
            ap_done_d = 1'b1;
            state_d   = S_DONE;
          end else begin
            state_d = S_WAIT_IN;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Tap BRAM port: engine owns it in MAC; the host only touches it when idle.
  always_comb begin
    tap_EN = 1'b0;
    tap_WE = '0;
    tap_A  = '0;
    tap_Di = '0;
    if (eng_tap_rd) begin
      tap_EN = 1'b1;
      tap_A  = eng_tap_a;
    end else if (tap_wr) begin
      tap_EN = 1'b1;
      tap_WE = '1;
      tap_A  = awaddr - TAP_BASE;
      tap_Di = wdata;
    end else if (rd_q == R_ADDR && host_idle && is_tap(araddr_q)) begin
      tap_EN = 1'b1;
      tap_A  = araddr_q - TAP_BASE;
    end
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state_q       <= S_IDLE;
      rd_q          <= R_IDLE;
      awready_q     <= 1'b0;
      araddr_q      <= '0;
      tap_rd_ok_q   <= 1'b0;
      rdata_q       <= '0;
      ap_done_q     <= 1'b0;
      data_length_q <= '0;
      cnt_q         <= '0;
      p_q           <= '0;
      dp_q          <= '0;
      acc_q         <= '0;
      y_q           <= '0;
    end else begin
      state_q       <= state_d;
      rd_q          <= rd_d;
      awready_q     <= wr_pending;
      araddr_q      <= araddr_d;
      tap_rd_ok_q   <= tap_rd_ok_d;
      rdata_q       <= rdata_d;
      ap_done_q     <= ap_done_d;
      data_length_q <= data_length_d;
      cnt_q         <= cnt_d;
      p_q           <= p_d;
      dp_q          <= dp_d;
      acc_q         <= acc_d;
      y_q           <= y_d;
    end
  end

endmodule

// File: tb/tb_fir_filter.sv
// Testbench for fir_filter: host configures over AXI-Lite, samples stream in,
// expected outputs are queued by a reference convolution when each sample is
// driven and compared when the DUT emits them. BRAMs are modelled here.
module tb_fir_filter;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int NT = 11;

  logic          axis_clk = 1'b0;
  logic          axis_rst_n;
  logic          awready, wready, awvalid, wvalid;
  logic [AW-1:0] awaddr;
  logic [DW-1:0] wdata;
  logic          arready, rready, arvalid, rvalid;
  logic [AW-1:0] araddr;
  logic [DW-1:0] rdata;
  logic          ss_tvalid, ss_tlast, ss_tready;
  logic [DW-1:0] ss_tdata;
  logic          sm_tready, sm_tvalid, sm_tlast;
  logic [DW-1:0] sm_tdata;
  logic [3:0]    tap_WE, data_WE;
  logic          tap_EN, data_EN;
  logic [DW-1:0] tap_Di, tap_Do, data_Di, data_Do;
  logic [AW-1:0] tap_A, data_A;

  always #5 axis_clk = ~axis_clk;

  fir_filter #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .Tape_Num(NT)) dut (
    .awready(awready), .wready(wready), .awvalid(awvalid), .awaddr(awaddr),
    .wvalid(wvalid), .wdata(wdata), .arready(arready), .rready(rready),
    .arvalid(arvalid), .araddr(araddr), .rvalid(rvalid), .rdata(rdata),
    .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast),
    .ss_tready(ss_tready), .sm_tready(sm_tready), .sm_tvalid(sm_tvalid),
    .sm_tdata(sm_tdata), .sm_tlast(sm_tlast),
    .tap_WE(tap_WE), .tap_EN(tap_EN), .tap_Di(tap_Di), .tap_A(tap_A), .tap_Do(tap_Do),
    .data_WE(data_WE), .data_EN(data_EN), .data_Di(data_Di), .data_A(data_A),
    .data_Do(data_Do), .axis_clk(axis_clk), .axis_rst_n(axis_rst_n)
  );

  // Single-port BRAM models: registered read of the old contents.
  logic [31:0] tap_ram  [NT];
  logic [31:0] data_ram [NT];

  always @(posedge axis_clk) begin : tap_bram
    int idx;
    idx = int'(tap_A >> 2);
    if (tap_EN && idx < NT) begin
      tap_Do <= tap_ram[idx];
      for (int b = 0; b < 4; b++)
        if (tap_WE[b]) tap_ram[idx][8*b +: 8] <= tap_Di[8*b +: 8];
    end
  end

  always @(posedge axis_clk) begin : data_bram
    int idx;
    idx = int'(data_A >> 2);
    if (data_EN && idx < NT) begin
      data_Do <= data_ram[idx];
      for (int b = 0; b < 4; b++)
        if (data_WE[b]) data_ram[idx][8*b +: 8] <= data_Di[8*b +: 8];
    end
  end

  typedef struct {
    logic [31:0] y;
    logic        last;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   h [NT] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int tri_wave(input int n);
    int m;
    m = n % 64;
    return ((m < 32) ? m : 64 - m) * 37 - 500;
  endfunction

  task automatic axil_write(input logic [AW-1:0] addr, input logic [31:0] data);
    bit ok;
    @(negedge axis_clk);
    awaddr = addr; wdata = data; awvalid = 1'b1; wvalid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge axis_clk);
      if (awready && wready) begin ok = 1'b1; break; end
    end
    check_eq("aw_w_handshake", 32'(ok), 32'd1);
    @(negedge axis_clk);
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic axil_read(input logic [AW-1:0] addr, output logic [31:0] data);
    bit ok;
    data = '0;
    @(negedge axis_clk);
    araddr = addr; arvalid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge axis_clk);
      if (arready) begin ok = 1'b1; break; end
    end
    @(negedge axis_clk);
    arvalid = 1'b0;
    if (ok) begin
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
        if (rvalid) begin ok = 1'b1; break; end
        @(negedge axis_clk);
      end
      if (ok) begin
        data = rdata;
        rready = 1'b1;
        @(negedge axis_clk);
        rready = 1'b0;
      end
    end
    check_eq("ar_r_handshake", 32'(ok), 32'd1);
  endtask

  task automatic configure(input int len);
    logic [31:0] rd;
    axil_write(12'h010, 32'(len));
    for (int k = 0; k < NT; k++) axil_write(12'(32 + 4 * k), 32'(h[k]));
    for (int k = 0; k < NT; k++) begin
      axil_read(12'(32 + 4 * k), rd);
      check_eq($sformatf("tap_rb%0d", k), rd, 32'(h[k]));
    end
    axil_read(12'h010, rd);
    check_eq("len_rb", rd, 32'(len));
  endtask

  task automatic start_run();
    logic [31:0] rd;
    axil_write(12'h000, 32'd1);
    axil_read(12'h000, rd);
    check_eq("idle_after_start", rd & 32'h4, 32'h0);
  endtask

  // Streams n_send samples of a run of length len; n_send < len aborts early.
  task automatic run_stream(input int len, input int n_send, input bit rnd_ready);
    int hist [NT];
    for (int k = 0; k < NT; k++) hist[k] = 0;
    sb_q.delete();
    fork
      begin : producer
        int x, yv;
        bit ok;
        for (int n = 0; n < n_send; n++) begin
          x = tri_wave(n);
          for (int k = NT - 1; k > 0; k--) hist[k] = hist[k-1];
          hist[0] = x;
          yv = 0;
          for (int k = 0; k < NT; k++) yv += h[k] * hist[k];
          sb_q.push_back('{y: 32'(yv), last: (n == len - 1)});
          @(negedge axis_clk);
          ss_tdata = 32'(x); ss_tlast = (n == len - 1); ss_tvalid = 1'b1;
          ok = 1'b0;
          for (int i = 0; i < 2000; i++) begin
            if (ss_tready) begin ok = 1'b1; break; end
            @(negedge axis_clk);
          end
          if (!ok) begin
            check_eq("ss_tready_timeout", 32'(ok), 32'd1);
            break;
          end
          @(negedge axis_clk);
          ss_tvalid = 1'b0; ss_tlast = 1'b0;
        end
        ss_tvalid = 1'b0;
      end
      begin : consumer
        exp_t e;
        bit   ok;
        for (int n = 0; n < n_send; n++) begin
          ok = 1'b0;
          for (int i = 0; i < 2000; i++) begin
            @(negedge axis_clk);
            sm_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (sm_tvalid && sm_tready) begin ok = 1'b1; break; end
          end
          if (!ok) begin
            check_eq("sm_tvalid_timeout", 32'(ok), 32'd1);
            break;
          end
          if (sb_q.size() == 0) begin
            check_eq("sb_unexpected_output", 32'(sb_q.size()), 32'd1);
          end else begin
            e = sb_q.pop_front();
            check_eq($sformatf("y[%0d]", n), sm_tdata, e.y);
            check_eq($sformatf("tlast[%0d]", n), 32'(sm_tlast), 32'(e.last));
          end
        end
        @(negedge axis_clk);
        sm_tready = 1'b0;
      end
      begin : busy_probe
        logic [31:0] rd;
        repeat (100) @(negedge axis_clk);
        axil_read(12'h000, rd);
        check_eq("ctrl_busy", rd & 32'hF, 32'h0);
        axil_read(12'h02C, rd);
        check_eq("tap_read_busy", rd, 32'h0);
        axil_write(12'h024, 32'h7777);
      end
    join
    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_awready"}, 32'(awready), 32'd0);
    check_eq({pfx, "_arready"}, 32'(arready), 32'd0);
    check_eq({pfx, "_rvalid"},  32'(rvalid),  32'd0);
    check_eq({pfx, "_rdata"},   rdata,        32'd0);
    check_eq({pfx, "_ss_tready"}, 32'(ss_tready), 32'd0);
    check_eq({pfx, "_sm_tvalid"}, 32'(sm_tvalid), 32'd0);
    check_eq({pfx, "_sm_tlast"},  32'(sm_tlast),  32'd0);
    check_eq({pfx, "_sm_tdata"},  sm_tdata,       32'd0);
    check_eq({pfx, "_bram_en"}, 32'({tap_EN, data_EN}), 32'd0);
    check_eq({pfx, "_bram_we"}, 32'({tap_WE, data_WE}), 32'd0);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    for (int i = 0; i < NT; i++) begin
      tap_ram[i]  = '0;
      data_ram[i] = 32'h1234_5678 + 32'(i);
    end
    axis_rst_n = 1'b0;
    awvalid = 1'b0; wvalid = 1'b0; awaddr = '0; wdata = '0;
    arvalid = 1'b0; araddr = '0; rready = 1'b0;
    ss_tvalid = 1'b0; ss_tdata = '0; ss_tlast = 1'b0; sm_tready = 1'b0;
    repeat (3) @(negedge axis_clk);
    check_reset_outputs("rst");
    axis_rst_n = 1'b1;
    @(negedge axis_clk);

    axil_read(12'h000, rd);
    check_eq("ctrl_reset", rd, 32'h4);
    axil_read(12'h010, rd);
    check_eq("len_reset", rd, 32'h0);
    axil_read(12'h0F0, rd);
    check_eq("unmapped_read", rd, 32'h0);

    // Run 1: full length, sink always ready.
    configure(600);
    start_run();
    run_stream(600, 600, 1'b0);
    repeat (3) @(negedge axis_clk);
    axil_read(12'h000, rd);
    check_eq("ctrl_done_run1", rd, 32'h6);
    axil_read(12'h024, rd);
    check_eq("tap1_after_busy_write", rd, 32'(h[1]));

    // Run 2: restart without reconfiguring, sink ready toggled randomly.
    start_run();
    run_stream(600, 600, 1'b1);
    repeat (3) @(negedge axis_clk);
    axil_read(12'h000, rd);
    check_eq("ctrl_done_run2", rd, 32'h6);

    // Run 3: abort with reset while an accumulation is in flight.
    start_run();
    run_stream(600, 30, 1'b0);
    @(negedge axis_clk);
    ss_tdata = 32'd123; ss_tvalid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (ss_tready) break;
      @(negedge axis_clk);
    end
    @(negedge axis_clk);
    ss_tvalid = 1'b0;
    repeat (4) @(negedge axis_clk);
    axis_rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(negedge axis_clk);
    axis_rst_n = 1'b1;
    axil_read(12'h000, rd);
    check_eq("ctrl_after_midrst", rd, 32'h4);
    axil_read(12'h010, rd);
    check_eq("len_after_midrst", rd, 32'h0);

    // Run 4: reconfigure after reset, short run.
    configure(20);
    start_run();
    run_stream(20, 20, 1'b1);
    repeat (3) @(negedge axis_clk);
    axil_read(12'h000, rd);
    check_eq("ctrl_done_run4", rd, 32'h6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
